// File: rtl/hex_seg_display_if.sv
// hex_seg_display_if: bundles the calculator-facing inputs and display outputs
// of the hex_seg_display block.
//   cal_result [31:0] : value to show, nibble k on digit k (digit 0 rightmost)
//   error             : calculator error flag, shows "Err" when set
//   led_en     [7:0]  : digit enables, active-low, bit k = digit k
//   seg        [7:0]  : segments a..g, dp, active-low
// master = calculator side (drives value/error), slave = display block.
interface hex_seg_display_if;
   logic [31:0] cal_result;
   logic        error;
   logic [7:0]  led_en;
   logic [7:0]  seg;

   modport master (output cal_result, output error, input led_en, input seg);
   modport slave  (input cal_result, input error, output led_en, output seg);
endinterface

// File: rtl/hex_seg_display.sv
// hex_seg_display: 8-digit common-anode time-multiplexed 7-segment driver.
// Each digit is lit for SCAN_DIV cycles. The input value and error flag are
// snapshotted once per frame (when the scan wraps from digit 7 to digit 0), so a
// frame never shows a mix of old and new data.
//   clk_g : clock, rising edge
//   rst   : synchronous active-high reset (display dark, scan restarts at digit 0)
//   bus   : slave side of hex_seg_display_if (cal_result/error in, led_en/seg out)
// Parameters:
//   SCAN_DIV : cycles per digit (>= 2)
//   BLANK_EN : 1 = blank leading-zero digits (digit 0 is never blanked)
module hex_seg_display #(
   parameter int SCAN_DIV = 100000,
   parameter int BLANK_EN = 1
) (
   input  logic              clk_g,
   input  logic              rst,
   hex_seg_display_if.slave  bus
);

   localparam int PW = $clog2(SCAN_DIV);

   logic [PW-1:0] pcnt;
   logic [2:0]    idx;
   logic [31:0]   val_s;
   logic          err_s;
   logic          tick;
   logic [31:0]   upper;
   logic [7:0]    seg_nxt;

   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'hC0;
         4'h1: hex7 = 8'hF9;
         4'h2: hex7 = 8'hA4;
         4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;
         4'h5: hex7 = 8'h92;
         4'h6: hex7 = 8'h82;
         4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;
         4'h9: hex7 = 8'h90;
         4'hA: hex7 = 8'h88;
         4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;
         4'hD: hex7 = 8'hA1;
         4'hE: hex7 = 8'h86;
         default: hex7 = 8'h8E;
      endcase
   endfunction

   assign tick  = (pcnt == PW'(SCAN_DIV - 1));
   // Shifting the current digit down to bit 0 gives both the nibble to decode
   // and, via the remaining upper bits, the leading-zero test in one step.
   assign upper = val_s >> {idx, 2'b00};

   always_comb begin
      seg_nxt = 8'hFF;
      if (err_s) begin
         case (idx)
            3'd2:       seg_nxt = 8'h86;   // 'E'
            3'd1, 3'd0: seg_nxt = 8'hAF;   // 'r'
            default:    seg_nxt = 8'hFF;
         endcase
      end else if ((BLANK_EN != 0) && (idx != 3'd0) && (upper == 32'd0)) begin
         seg_nxt = 8'hFF;
      end else begin
         seg_nxt = hex7(upper[3:0]);
      end
   end

   always_ff @(posedge clk_g) begin
      if (rst) begin
         pcnt       <= '0;
         idx        <= 3'd0;
         val_s      <= 32'd0;
         err_s      <= 1'b0;
         bus.led_en <= 8'hFF;
         bus.seg    <= 8'hFF;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (tick) begin
            idx <= idx + 3'd1;
            // Snapshot on the 7->0 wrap so the next frame starts with fresh data.
            if (idx == 3'd7) begin
               val_s <= bus.cal_result;
               err_s <= bus.error;
            end
         end
         // Outputs follow idx/val_s/err_s one cycle late; blanked digits stay
         // enabled with all segments off to keep a uniform duty cycle.
         bus.led_en <= ~(8'b1 << idx);
         bus.seg    <= seg_nxt;
      end
   end

endmodule
